// File: rtl/bsg_chip_pkg.sv
// Chip-level shared constants and types for the memory-link arbiter.
package bsg_chip_pkg;

  localparam int mem_link_arb_num_in_gp     = 4;
  localparam int mem_link_arb_len_width_gp  = 4;
  localparam int mem_link_arb_len_offset_gp = 0;

  typedef struct packed {
    logic [mem_link_arb_len_width_gp-1:0] len;
  } mem_link_arb_hdr_s;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } mem_link_arb_state_e;

endpackage

// File: rtl/bsg_chip_mem_link_arb_rr.sv
// Combinational round-robin pick: first valid requester at or after ptr_i.
module bsg_chip_mem_link_arb_rr #(
  parameter int num_in_p = 4,
  parameter int lg_p     = 2
) (
  input  logic [num_in_p-1:0] v_i,
  input  logic [lg_p-1:0]     ptr_i,
  output logic [num_in_p-1:0] pick_oh_o,
  output logic [lg_p-1:0]     pick_o,
  output logic                found_o
);

  always_comb begin
    int idx;
    idx       = 0;
    pick_oh_o = '0;
    pick_o    = '0;
    found_o   = 1'b0;
    // Scan farthest-first so the closest valid requester to ptr_i wins.
    for (int k = num_in_p - 1; k >= 0; k--) begin
      idx = (int'(ptr_i) + k) % num_in_p;
      if (v_i[idx]) begin
        pick_o  = lg_p'(idx);
        found_o = 1'b1;
      end
    end
    if (found_o) pick_oh_o[pick_o] = 1'b1;
  end

endmodule

// File: rtl/bsg_chip_mem_link_arb.sv
// Wormhole round-robin arbiter onto one memory-link ready/valid channel.
// Optional mid-packet stall counter: BSG_CHIP_MEM_LINK_ARB_STALL_CNT_EN.
module bsg_chip_mem_link_arb
  import bsg_chip_pkg::*;
#(
  parameter int num_in_p     = mem_link_arb_num_in_gp,
  parameter int width_p      = 64,
  parameter int len_width_p  = mem_link_arb_len_width_gp,
  parameter int len_offset_p = mem_link_arb_len_offset_gp,
  localparam int lg_lp       = (num_in_p > 1) ? $clog2(num_in_p) : 1
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic [num_in_p-1:0]         v_i,
  input  logic [num_in_p*width_p-1:0] data_i,
  output logic [num_in_p-1:0]         ready_and_o,
  output logic                        v_o,
  output logic [width_p-1:0]          data_o,
  input  logic                        ready_and_i,
  output logic [lg_lp-1:0]            grant_o,
  output logic [31:0]                 stall_cnt_o
);

  mem_link_arb_state_e state_q, state_d;
  logic [lg_lp-1:0]       rr_ptr_q, rr_ptr_d;
  logic [lg_lp-1:0]       owner_q, owner_d;
  logic [len_width_p-1:0] cnt_q, cnt_d;

  logic [num_in_p-1:0]              pick_oh;
  logic [lg_lp-1:0]                 pick;
  logic                             found;
  logic [lg_lp-1:0]                 sel;
  logic                             busy, hs;
  logic [len_width_p-1:0]           hdr_len;
  logic [num_in_p-1:0][width_p-1:0] data_arr;

  bsg_chip_mem_link_arb_rr #(.num_in_p(num_in_p), .lg_p(lg_lp)) rr (
    .v_i      (v_i),
    .ptr_i    (rr_ptr_q),
    .pick_oh_o(pick_oh),
    .pick_o   (pick),
    .found_o  (found)
  );

  assign data_arr = data_i;
  assign busy     = (state_q == ARB_BUSY);
  assign sel      = busy ? owner_q : pick;
  assign v_o      = ~reset_i & v_i[sel];
  assign data_o   = data_arr[sel];
  assign grant_o  = sel;
  assign hs       = v_o & ready_and_i;
  assign hdr_len  = data_o[len_offset_p +: len_width_p];

  // Owner keeps the accept while BUSY even if its valid drops.
  for (genvar i = 0; i < num_in_p; i++) begin : g_rdy
    assign ready_and_o[i] = ~reset_i & ready_and_i
                          & (busy ? (owner_q == lg_lp'(i)) : (found & pick_oh[i]));
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    case (state_q)
      ARB_IDLE: if (hs) begin
        rr_ptr_d = (pick == lg_lp'(num_in_p - 1)) ? '0 : pick + lg_lp'(1);
        if (hdr_len != '0) begin
          state_d = ARB_BUSY;
          owner_d = pick;
          cnt_d   = hdr_len;
        end
      end
      ARB_BUSY: if (hs) begin
        cnt_d = cnt_q - len_width_p'(1);
        if (cnt_q == len_width_p'(1)) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= ARB_IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
    end
  end

`ifdef BSG_CHIP_MEM_LINK_ARB_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (busy && v_o && !ready_and_i && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) stall_cnt_q <= '0;
    else         stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt_o = stall_cnt_q;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: doc/bsg_chip_mem_link_arb.md
# bsg_chip_mem_link_arb

Wormhole-aware round-robin arbiter that shares one memory-link ready/valid channel among `num_in_p` requesters in the HB core clock domain. It sits between the core-side requesters and the core-side `links_i` input of one `bsg_chip_io_links_ct_fifo` memory-link instance. Once a header flit is granted, the arbiter holds that grant until the whole packet (header plus `len` body flits) has transferred, so packets are never interleaved on the link.

## Interface
Parameters:
- `num_in_p`, 4 — number of requesters; must be ≥ 2.
- `width_p`, 64 — flit width; equals the memory-link flit width.
- `len_width_p`, 4 — width of the body-flit-count field in a header flit.
- `len_offset_p`, 0 — LSB position of the len field inside `data_i`.

Ports:
- `clk_i`  in  1 — core clock. One clock; all logic in this domain.
- `reset_i`  in  1 — synchronous, active-high reset.
- `v_i`  in  `num_in_p` — per-requester flit valid.
- `data_i`  in  `num_in_p*width_p` — per-requester flit data.
- `ready_and_o`  out  `num_in_p` — per-requester accept.
- `v_o`  out  1 — flit valid toward the link.
- `data_o`  out  `width_p` — flit data toward the link.
- `ready_and_i`  in  1 — link accept.
- `grant_o`  out  `lg(num_in_p)` — index of the current owner; valid while `v_o` is high.
- `stall_cnt_o`  out  32 — mid-packet stall counter (see Configuration).

## Operation
- State machine:
  - **IDLE**: no owner. The round-robin pick starts at `rr_ptr_r` and selects the first requester with `v_i` set. The header is forwarded the same cycle.
  - **BUSY**: owner locked in `owner_r`; remaining body flits held in `cnt_r`.
- A handshake is `v_o & ready_and_i`.
- IDLE transitions on a header handshake:
  - `len == 0`: stay in IDLE; `rr_ptr_r` ← pick+1 (mod `num_in_p`).
  - `len > 0`: go to BUSY; `owner_r` ← pick; `cnt_r` ← len; `rr_ptr_r` ← pick+1.
- BUSY: each handshake decrements `cnt_r`. A handshake with `cnt_r == 1` returns to IDLE.
- Output muxing:
  - `ready_and_o[i] = ready_and_i` for the current pick/owner `i`; 0 for all other requesters.
  - `data_o` / `v_o` mux the pick/owner's `data_i` / `v_i`.
- The pick is registered only on handshake. If `ready_and_i` is low in IDLE, the pick is recomputed each cycle and may change. Requesters must hold `v_i` / data until accepted.
- Owner drops `v_i` mid-packet: `v_o` goes low and the grant is still held; no other requester is served.
- `rr_ptr_r` wraps from `num_in_p-1` to 0.
- `len` is interpreted as unsigned. The maximum packet is 2^`len_width_p` flits.

## Timing
- Zero-cycle forwarding: combinational paths `v_i`/`data_i` → `v_o`/`data_o`, and `ready_and_i` → `ready_and_o`.
- Back-to-back single-flit packets from different requesters: one per cycle.
- After the last body flit, the next header is accepted the following cycle, never the same cycle.
- Reset values: state IDLE, `rr_ptr_r` = 0, `cnt_r` = 0, `owner_r` = 0, `stall_cnt_o` = 0.
  - While reset is high: `v_o` = 0 and `ready_and_o` = 0.
- Reset asserted mid-packet aborts the packet. The next cycle is IDLE with `rr_ptr_r` = 0; any remaining body flits are the requester's responsibility.

## Configuration
- `BSG_CHIP_MEM_LINK_ARB_STALL_CNT_EN`
  - Defined: `stall_cnt_o` counts cycles in BUSY where `v_o & ~ready_and_i`. It saturates at 2^32−1 and clears on reset.
  - Undefined: no counter is built; `stall_cnt_o` is tied to 0.

## Structure
- Add to `bsg_chip_pkg`:
  - `mem_link_arb_num_in_gp`
  - `mem_link_arb_len_width_gp`
  - `mem_link_arb_len_offset_gp`
  - packed header struct `mem_link_arb_hdr_s` carrying the len field
- One sub-module, `bsg_chip_mem_link_arb_rr`: combinational round-robin pick from (`v_i`, `rr_ptr_r`), producing the one-hot and encoded pick.
- FSM, counter and muxes live in the top module.

## Test plan
- Requesters 0 and 2 both present single-flit packets every cycle, `ready_and_i` = 1 → grants alternate 0,2,0,2 with one flit per cycle.
- Requester 1 sends a header with len=3 while requester 3 is also valid → four consecutive flits from 1, then 3's header in the fifth cycle; `ready_and_o[3]` = 0 during cycles 1–4.
- `ready_and_i` low for 5 cycles mid-packet (len=2), with the macro defined → `stall_cnt_o` = 5; packet completes intact; grant unchanged throughout.
- Reset pulsed after the second flit of a len=4 packet → next cycle IDLE, `rr_ptr_r` = 0; requester 0's pending header is granted first.
- Owner deasserts `v_i` for 3 cycles mid-packet while requester 0 is valid → `v_o` = 0 and `ready_and_o[0]` = 0 for those 3 cycles; the packet resumes on the same owner.
- `len` = 2^`len_width_p`−1 packet from requester `num_in_p`−1 → exactly 2^`len_width_p` flits, then `rr_ptr_r` wraps to 0.
